shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Step sequencer for a generative melody voice bank. A free-running divider
// produces one step per 2^DIV_WIDTH clk cycles. On every step the pattern
// shift register is updated according to the feed mode. The register is then
// tapped at four rotated positions per voice to form a 4-bit scale degree,
// together with a per-voice note gate.
//
// Timing, where E is the clock edge at which the divider is all-ones:
//   edge E   : sr updates and step_tick is registered high
//   edge E+1 : scale_degree and gate load from the updated sr, and the
//              optional gate-length counter is reloaded
//
// Parameters
//   SR_WIDTH     pattern shift-register length (>= 8)
//   DIV_WIDTH    step period is 2^DIV_WIDTH clk cycles
//   NUM_VOICES   number of voices (1..4)
//   VOICE_OFFSET tap rotation between successive voices
//   LFSR_TAP     second feedback tap in LFSR mode (1..SR_WIDTH-1)
//   GATE_CYCLES  gate length in clk cycles; 0 means legato (full step)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   data_in      asynchronous pattern bit; it is synchronized internally
//   mode         feed mode: 0 external, 1 loop, 2 LFSR, 3 hold
//   step_tick    one-cycle pulse per step
//   sr_state     current shift-register contents
//   scale_degree per-voice 4-bit degree; voice v is at [4v+3:4v]
//   gate         per-voice note gate
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int SR_WIDTH     = 8,
  parameter int DIV_WIDTH    = 20,
  parameter int NUM_VOICES   = 2,
  parameter int VOICE_OFFSET = 1,
  parameter int LFSR_TAP     = 1,
  parameter int GATE_CYCLES  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_in,
  input  logic [1:0]              mode,
  output logic                    step_tick,
  output logic [SR_WIDTH-1:0]     sr_state,
  output logic [4*NUM_VOICES-1:0] scale_degree,
  output logic [NUM_VOICES-1:0]   gate
);

  // Feed-mode encodings.
  localparam logic [1:0] MODE_EXT  = 2'd0;
  localparam logic [1:0] MODE_LOOP = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  // A gate longer than the step period would never be seen to end before the
  // next retrigger, so its length is clamped to one full step.
  localparam int STEP_PERIOD = 2 ** DIV_WIDTH;
  localparam int GATE_LEN    = (GATE_CYCLES >= STEP_PERIOD) ? STEP_PERIOD : GATE_CYCLES;

  // One extra bit so the counter can hold a full step period.
  localparam int GCNT_W = DIV_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    sync_meta_q, sync_meta_d;
  logic                    data_s_q,    data_s_d;
  logic [DIV_WIDTH-1:0]    div_q,       div_d;
  logic [SR_WIDTH-1:0]     sr_q,        sr_d;
  logic                    step_tick_q, step_tick_d;
  logic [4*NUM_VOICES-1:0] degree_q,    degree_d;
  logic [NUM_VOICES-1:0]   gate_q,      gate_d;
  logic [GCNT_W-1:0]       gcnt_q,      gcnt_d;

  logic                    step_edge;
  logic [4*NUM_VOICES-1:0] voice_deg;
  logic [NUM_VOICES-1:0]   voice_gate;

  // ---------------------------------------------------------------------------
  // Voice taps: these are fixed rotations of sr, so every index is a
  // compile-time constant and no multiplexing is needed.
  // ---------------------------------------------------------------------------
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    localparam int K  = (v * VOICE_OFFSET) % SR_WIDTH;
    localparam int I3 = (2 + K) % SR_WIDTH;
    localparam int I2 = (3 + K) % SR_WIDTH;
    localparam int I1 = (5 + K) % SR_WIDTH;
    localparam int I0 = (7 + K) % SR_WIDTH;

    assign voice_deg[4*v +: 4] = {sr_q[I3], sr_q[I2], sr_q[I1], sr_q[I0]};
    assign voice_gate[v]       = |voice_deg[4*v +: 4];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sync_meta_d = data_in;
    data_s_d    = sync_meta_q;

    div_d       = div_q + DIV_WIDTH'(1);
    step_edge   = &div_q;
    step_tick_d = step_edge;

    // mode is only looked at on the step edge, so mode changes made between
    // steps take effect at the next step.
    sr_d = sr_q;
    if (step_edge) begin
      unique case (mode)
        MODE_EXT:  sr_d = {data_s_q, sr_q[SR_WIDTH-1:1]};
        MODE_LOOP: sr_d = {sr_q[0], sr_q[SR_WIDTH-1:1]};
        MODE_LFSR: begin
          // The all-zero state would lock the LFSR; seed a single one at the
          // MSB instead.
          if (sr_q == '0) begin
            sr_d = {1'b1, {(SR_WIDTH-1){1'b0}}};
          end else begin
            sr_d = {sr_q[0] ^ sr_q[LFSR_TAP], sr_q[SR_WIDTH-1:1]};
          end
        end
        MODE_HOLD: sr_d = sr_q;
        default:   sr_d = sr_q;
      endcase
    end

    degree_d = degree_q;
    gate_d   = gate_q;
    gcnt_d   = gcnt_q;

    // Timed gate: the counter is loaded with the gate length on the retrigger
    // edge, so the gates drop exactly GATE_LEN cycles after they rise.
    if (GATE_LEN > 0 && gcnt_q != '0) begin
      gcnt_d = gcnt_q - GCNT_W'(1);
      if (gcnt_q == GCNT_W'(1)) begin
        gate_d = '0;
      end
    end

    // The retrigger edge wins over the gate release. With a saturated gate
    // length both coincide, which gives legato output.
    if (step_tick_q) begin
      degree_d = voice_deg;
      gate_d   = voice_gate;
      if (GATE_LEN > 0) begin
        gcnt_d = GCNT_W'(GATE_LEN);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      data_s_q    <= 1'b0;
      div_q       <= '0;
      sr_q        <= '0;
      step_tick_q <= 1'b0;
      degree_q    <= '0;
      gate_q      <= '0;
      gcnt_q      <= '0;
    end else begin
      sync_meta_q <= sync_meta_d;
      data_s_q    <= data_s_d;
      div_q       <= div_d;
      sr_q        <= sr_d;
      step_tick_q <= step_tick_d;
      degree_q    <= degree_d;
      gate_q      <= gate_d;
      gcnt_q      <= gcnt_d;
    end
  end

  assign step_tick    = step_tick_q;
  assign sr_state     = sr_q;
  assign scale_degree = degree_q;
  assign gate         = gate_q;

endmodule
